motor_panel_ctrl: RTL and testbench
===================================

# motor_panel_ctrl

Front-panel command stage for the stepper drive. It debounces four active-low push-buttons and turns them into the `startsig`, `directsig` and `speed[3:0]` levels that the step-sequencer block consumes. A safe-reversal state machine guarantees the motor is stopped for a fixed dwell before the direction changes.

## Interface
- `CLK_PER_MS`, default 50000: clock cycles per millisecond (50 MHz).
- `DEBOUNCE_MS`, default 20: required stable time before a key level is accepted.
- `DWELL_MS`, default 50: stop time before a direction change while running.
- `SPEED_INIT`, default 4: `speed` value after reset.
- `SPEED_MIN`, default 1: lowest `speed` value (fastest). The maximum is 15 (slowest).
- `clk` in 1: single system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `key_start_n` in 1: start/stop toggle key, active-low, asynchronous.
- `key_dir_n` in 1: direction toggle key, active-low, asynchronous.
- `key_fast_n` in 1: speed-up key, active-low, asynchronous.
- `key_slow_n` in 1: slow-down key, active-low, asynchronous.
- `startsig` out 1: motor enable level for the sequencer.
- `directsig` out 1: 1 = forward, 0 = reverse.
- `speed` out 4: step period code; a larger value gives a slower step.
- `busy` out 1: high while a reversal dwell is in progress.

## Operation
- **Key path (per key):**
  - 2-flop synchroniser.
  - Debounce counter that accepts a new level only after it has been stable for `DEBOUNCE_MS × CLK_PER_MS` consecutive cycles. Any bounce restarts the counter.
  - Accepted falling edge (press) produces a one-cycle `press` pulse. Release produces no pulse.
- **FSM states:**
  - IDLE: `startsig` = 0.
  - RUN: `startsig` = 1.
  - STOPPING: `startsig` = 0, `busy` = 1, dwell counter running.
- **IDLE transitions:**
  - start press → RUN.
  - dir press → toggle `directsig` and stay in IDLE.
- **RUN transitions:**
  - start press → IDLE.
  - dir press → STOPPING, with the dwell counter cleared.
- **STOPPING transitions:**
  - Dwell of `DWELL_MS × CLK_PER_MS` cycles complete → toggle `directsig`, go to RUN.
  - start press → IDLE, reversal aborted, `directsig` unchanged.
  - dir press → ignored.
- **Speed control (any state):**
  - fast press → `speed` decrements, saturating at `SPEED_MIN`.
  - slow press → `speed` increments, saturating at 15.
- **Simultaneous events:**
  - start and dir pulses in the same cycle: start wins, dir is dropped.
  - fast and slow pulses in the same cycle: both are dropped.
- **Width rule:** `speed` never leaves the range [`SPEED_MIN`, 15], so `speed` + 1 downstream never overflows a 5-bit compare.

## Timing
- **Reset values:**
  - `startsig` = 0.
  - `directsig` = 1.
  - `speed` = `SPEED_INIT`.
  - `busy` = 0.
  - State = IDLE.
  - All counters and synchronisers cleared; synchroniser and debounce stages reset to the released level (1).
- **Reset mid-dwell:** abandons the reversal; outputs return to their reset values on the same edge.
- **Press latency:** the `press` pulse occurs exactly 2 + D cycles after the first `clk` edge that samples a clean low, where D = `DEBOUNCE_MS × CLK_PER_MS`.
- **Output latency:** all outputs are registered and change on the cycle after the `press` pulse.
- **Reversal timing:** `startsig` falls 1 cycle after the dir pulse. `directsig` toggles and `startsig` rises together, exactly `DWELL_MS × CLK_PER_MS` cycles after `startsig` fell. `busy` is high for exactly those cycles.
- **Held keys:** a key held indefinitely produces a single pulse; there is no auto-repeat.

## Structure
- Shared package `motor_pkg`:
  - FSM state encoding (IDLE, RUN, STOPPING).
  - `SPEED_MAX` = 15.
  - Default `CLK_PER_MS`.
- Sub-module `key_debounce`, instantiated four times:
  - Parameters: `CLK_PER_MS`, `DEBOUNCE_MS`.
  - Ports: `clk`, `rst`, `key_n`, `press`.
- Top level holds the FSM, the dwell counter and the speed register.

## Test plan
Bench parameters: `CLK_PER_MS` = 10, `DEBOUNCE_MS` = 2, `DWELL_MS` = 3, `SPEED_INIT` = 4, `SPEED_MIN` = 1.
- **Debounce:** `key_start_n` low with 5 bounces of 7 cycles each, then held low → exactly one start pulse, 22 cycles after the last bounce; `startsig` rises 1 cycle later; no pulse on release.
- **Reversal:** in RUN with `directsig` = 1, press dir → `startsig` = 0 and `busy` = 1 for 30 cycles, then `directsig` = 0 and `startsig` = 1 on the same cycle.
- **Abort:** dir press in RUN, then start press 10 cycles into the dwell → IDLE, `directsig` still 1, `busy` = 0.
- **Speed saturation:** 5 fast presses from 4 give 3, 2, 1, 1, 1; then 16 slow presses end at 15 and hold there.
- **Simultaneous presses:**
  - start and dir pressed so their pulses coincide in IDLE → RUN, `directsig` unchanged.
  - fast and slow coincident → `speed` unchanged.
- **Reset mid-dwell:** assert `rst` for 1 cycle during STOPPING → immediately `startsig` = 0, `directsig` = 1, `speed` = 4, `busy` = 0; after release, the next start press gives RUN.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared definitions for the stepper front-panel command stage.
package motor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_t;

   localparam logic [3:0] SPEED_MAX      = 4'd15;
   localparam int         CLK_PER_MS_DEF = 50000;

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low key; one-cycle press pulse on accepted press.
// Pulse is registered 2 + CLK_PER_MS*DEBOUNCE_MS cycles after the first edge sampling a clean low; no backpressure.
module key_debounce
   import motor_pkg::*;
#(
   parameter int CLK_PER_MS  = CLK_PER_MS_DEF,
   parameter int DEBOUNCE_MS = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   localparam int D  = CLK_PER_MS * DEBOUNCE_MS;
   localparam int CW = $clog2(D + 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // Level is accepted once the new value has been seen on D+1 consecutive edges,
   // which places the pulse exactly two synchroniser cycles plus D after the first sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(D)) begin
            level <= sync2;
            cnt   <= '0;
            press <= ~sync2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/motor_panel_ctrl.sv
// Front-panel command stage: debounced keys drive start/direction/speed with a safe-reversal dwell.
// Outputs registered one cycle after a key press pulse; no backpressure, presses are never queued.
module motor_panel_ctrl
   import motor_pkg::*;
#(
   parameter int CLK_PER_MS  = CLK_PER_MS_DEF,
   parameter int DEBOUNCE_MS = 20,
   parameter int DWELL_MS    = 50,
   parameter int SPEED_INIT  = 4,
   parameter int SPEED_MIN   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_start_n,
   input  logic       key_dir_n,
   input  logic       key_fast_n,
   input  logic       key_slow_n,
   output logic       startsig,
   output logic       directsig,
   output logic [3:0] speed,
   output logic       busy
);

   localparam int         W    = CLK_PER_MS * DWELL_MS;
   localparam int         WW   = $clog2(W + 1);
   localparam logic [3:0] SINI = 4'(SPEED_INIT);
   localparam logic [3:0] SMIN = 4'(SPEED_MIN);

   logic p_start, p_dir, p_fast, p_slow;

   key_debounce #(.CLK_PER_MS(CLK_PER_MS), .DEBOUNCE_MS(DEBOUNCE_MS)) u_start (
      .clk(clk), .rst(rst), .key_n(key_start_n), .press(p_start));
   key_debounce #(.CLK_PER_MS(CLK_PER_MS), .DEBOUNCE_MS(DEBOUNCE_MS)) u_dir (
      .clk(clk), .rst(rst), .key_n(key_dir_n), .press(p_dir));
   key_debounce #(.CLK_PER_MS(CLK_PER_MS), .DEBOUNCE_MS(DEBOUNCE_MS)) u_fast (
      .clk(clk), .rst(rst), .key_n(key_fast_n), .press(p_fast));
   key_debounce #(.CLK_PER_MS(CLK_PER_MS), .DEBOUNCE_MS(DEBOUNCE_MS)) u_slow (
      .clk(clk), .rst(rst), .key_n(key_slow_n), .press(p_slow));

   state_t        state, state_n;
   logic [WW-1:0] dwell, dwell_n;
   logic          dir_n;
   logic [3:0]    speed_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         dwell     <= '0;
         directsig <= 1'b1;
         speed     <= SINI;
         startsig  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         dwell     <= dwell_n;
         directsig <= dir_n;
         speed     <= speed_n;
         startsig  <= (state_n == ST_RUN);
         busy      <= (state_n == ST_STOPPING);
      end
   end

   // Start always takes priority over dir, so a coincident dir press is dropped.
   always_comb begin
      state_n = state;
      dwell_n = dwell;
      dir_n   = directsig;
      speed_n = speed;
      unique case (state)
         ST_IDLE: begin
            if (p_start)    state_n = ST_RUN;
            else if (p_dir) dir_n   = ~directsig;
         end
         ST_RUN: begin
            if (p_start) begin
               state_n = ST_IDLE;
            end else if (p_dir) begin
               state_n = ST_STOPPING;
               dwell_n = '0;
            end
         end
         ST_STOPPING: begin
            if (p_start) begin
               state_n = ST_IDLE;
               dwell_n = '0;
            end else if (dwell == WW'(W - 1)) begin
               state_n = ST_RUN;
               dir_n   = ~directsig;
               dwell_n = '0;
            end else begin
               dwell_n = dwell + WW'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (p_fast && !p_slow && speed > SMIN)
         speed_n = speed - 4'd1;
      else if (p_slow && !p_fast && speed < SPEED_MAX)
         speed_n = speed + 4'd1;
   end

endmodule

// File: tb/tb_motor_panel_ctrl.sv
// Directed bench for motor_panel_ctrl with short debounce/dwell parameters.
module tb_motor_panel_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       k_start, k_dir, k_fast, k_slow;
   logic       startsig, directsig, busy;
   logic [3:0] speed;
   int         n_vec = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   motor_panel_ctrl #(
      .CLK_PER_MS(10), .DEBOUNCE_MS(2), .DWELL_MS(3), .SPEED_INIT(4), .SPEED_MIN(1)
   ) dut (
      .clk(clk), .rst(rst),
      .key_start_n(k_start), .key_dir_n(k_dir), .key_fast_n(k_fast), .key_slow_n(k_slow),
      .startsig(startsig), .directsig(directsig), .speed(speed), .busy(busy)
   );

   // Presses a key long enough for the outputs to update, then releases and lets it settle.
   task automatic press_key(input int idx);
      case (idx)
         0: k_start = 1'b0;
         1: k_dir   = 1'b0;
         2: k_fast  = 1'b0;
         default: k_slow = 1'b0;
      endcase
      repeat (24) @(negedge clk);
      k_start = 1'b1; k_dir = 1'b1; k_fast = 1'b1; k_slow = 1'b1;
      repeat (26) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      k_start = 1'b1; k_dir = 1'b1; k_fast = 1'b1; k_slow = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++; if (startsig !== 1'b0) begin n_err++; $display("FAIL rst_start got %b want 0", startsig); end
      n_vec++; if (directsig !== 1'b1) begin n_err++; $display("FAIL rst_dir got %b want 1", directsig); end
      n_vec++; if (speed !== 4'd4) begin n_err++; $display("FAIL rst_speed got %0d want 4", speed); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_debounce();
      for (int b = 0; b < 5; b++) begin
         k_start = 1'b0; repeat (7) @(negedge clk);
         k_start = 1'b1; repeat (7) @(negedge clk);
      end
      k_start = 1'b0;
      repeat (23) @(negedge clk);
      n_vec++; if (startsig !== 1'b0) begin n_err++; $display("FAIL deb_early startsig got %b want 0", startsig); end
      @(negedge clk);
      n_vec++; if (startsig !== 1'b1) begin n_err++; $display("FAIL deb_rise startsig got %b want 1", startsig); end
      repeat (40) @(negedge clk);
      n_vec++; if (startsig !== 1'b1) begin n_err++; $display("FAIL deb_held startsig got %b want 1", startsig); end
      k_start = 1'b1;
      repeat (40) @(negedge clk);
      n_vec++; if (startsig !== 1'b1) begin n_err++; $display("FAIL deb_release startsig got %b want 1", startsig); end
   endtask

   task automatic test_abort();
      k_dir = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (i == 10) k_start = 1'b0;
         if (i == 40) begin k_start = 1'b1; k_dir = 1'b1; end
         if (i == 24) begin
            n_vec++; if (busy !== 1'b1 || startsig !== 1'b0) begin n_err++; $display("FAIL abort_enter busy=%b startsig=%b want 1/0", busy, startsig); end
         end
         if (i == 33) begin
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_pre busy got %b want 1", busy); end
         end
         if (i == 34) begin
            n_vec++; if (busy !== 1'b0 || startsig !== 1'b0 || directsig !== 1'b1) begin
               n_err++; $display("FAIL abort_idle busy=%b start=%b dir=%b want 0/0/1", busy, startsig, directsig); end
         end
      end
      n_vec++; if (directsig !== 1'b1 || startsig !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL abort_settle busy=%b start=%b dir=%b want 0/0/1", busy, startsig, directsig); end
      press_key(0);
      n_vec++; if (startsig !== 1'b1) begin n_err++; $display("FAIL abort_restart startsig got %b want 1", startsig); end
   endtask

   task automatic test_reversal();
      int busy_cnt = 0;
      k_dir = 1'b0;
      for (int i = 1; i <= 70; i++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         if (i == 30) k_dir = 1'b1;
         if (i == 23) begin
            n_vec++; if (startsig !== 1'b1) begin n_err++; $display("FAIL rev_pre startsig got %b want 1", startsig); end
         end
         if (i == 24) begin
            n_vec++; if (startsig !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL rev_stop start=%b busy=%b want 0/1", startsig, busy); end
         end
         if (i == 53) begin
            n_vec++; if (directsig !== 1'b1 || busy !== 1'b1 || startsig !== 1'b0) begin
               n_err++; $display("FAIL rev_last start=%b dir=%b busy=%b want 0/1/1", startsig, directsig, busy); end
         end
         if (i == 54) begin
            n_vec++; if (directsig !== 1'b0 || startsig !== 1'b1 || busy !== 1'b0) begin
               n_err++; $display("FAIL rev_done start=%b dir=%b busy=%b want 1/0/0", startsig, directsig, busy); end
         end
      end
      n_vec++; if (busy_cnt != 30) begin n_err++; $display("FAIL rev_busy_len got %0d want 30", busy_cnt); end
   endtask

   task automatic test_speed();
      logic [3:0] exp_fast [5] = '{4'd3, 4'd2, 4'd1, 4'd1, 4'd1};
      for (int i = 0; i < 5; i++) begin
         press_key(2);
         n_vec++; if (speed !== exp_fast[i]) begin n_err++; $display("FAIL speed_fast%0d got %0d want %0d", i, speed, exp_fast[i]); end
      end
      for (int i = 0; i < 16; i++) begin
         press_key(3);
         n_vec++; if (speed !== ((i + 2 > 15) ? 4'd15 : 4'(i + 2))) begin
            n_err++; $display("FAIL speed_slow%0d got %0d want %0d", i, speed, (i + 2 > 15) ? 15 : i + 2); end
      end
   endtask

   task automatic test_simultaneous();
      press_key(0);
      n_vec++; if (startsig !== 1'b0) begin n_err++; $display("FAIL sim_idle startsig got %b want 0", startsig); end
      k_start = 1'b0; k_dir = 1'b0;
      repeat (24) @(negedge clk);
      n_vec++; if (startsig !== 1'b1 || directsig !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL sim_start_dir start=%b dir=%b busy=%b want 1/0/0", startsig, directsig, busy); end
      k_start = 1'b1; k_dir = 1'b1;
      repeat (26) @(negedge clk);
      press_key(2);
      n_vec++; if (speed !== 4'd14) begin n_err++; $display("FAIL sim_pre_speed got %0d want 14", speed); end
      k_fast = 1'b0; k_slow = 1'b0;
      repeat (24) @(negedge clk);
      n_vec++; if (speed !== 4'd14) begin n_err++; $display("FAIL sim_fast_slow got %0d want 14", speed); end
      k_fast = 1'b1; k_slow = 1'b1;
      repeat (26) @(negedge clk);
   endtask

   task automatic test_reset_mid_dwell();
      k_dir = 1'b0;
      repeat (26) @(negedge clk);
      k_dir = 1'b1;
      repeat (9) @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmd_dwell busy got %b want 1", busy); end
      rst = 1'b1;
      #1;
      n_vec++; if (startsig !== 1'b0 || directsig !== 1'b1 || speed !== 4'd4 || busy !== 1'b0) begin
         n_err++; $display("FAIL rmd_reset start=%b dir=%b speed=%0d busy=%b want 0/1/4/0", startsig, directsig, speed, busy); end
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      n_vec++; if (startsig !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmd_quiet start=%b busy=%b want 0/0", startsig, busy); end
      press_key(0);
      n_vec++; if (startsig !== 1'b1 || directsig !== 1'b1) begin
         n_err++; $display("FAIL rmd_run start=%b dir=%b want 1/1", startsig, directsig); end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_abort();
      test_reversal();
      test_speed();
      test_simultaneous();
      test_reset_mid_dwell();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
